// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: `common` holds the machine word and reset PC,
// `pipes` holds the inter-stage payloads and the fetch FSM state encoding.
package common;
    typedef logic [63:0] word_t;
    localparam word_t RESET_PC_DEFAULT = 64'h8000_0000;
endpackage

package pipes;
    import common::*;

    typedef struct packed {
        logic        valid;
        word_t       pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        word_t       pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {REQ, FULL, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Small in-order buffer (depth 1 or 2) of fetched {pc, instr} pairs awaiting decode.
// Flush wins over push/pop; a push and pop in the same cycle is legal even when full.
module fetch_queue
    import pipes::*;
#(
    parameter logic [1:0] DEPTH = 2'd1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full_next
);
    fetch_entry_t entry0;
    fetch_entry_t entry1;
    logic [1:0]   count_next;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = 2'd0;
        else if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    assign full_next = (count_next == DEPTH);
    assign head      = entry0;

    // entry0 is always the oldest entry; entry1 only ever holds the second-oldest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            count <= count_next;
            if (!flush) begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0)
                            entry0 <= push_entry;
                        else
                            entry1 <= push_entry;
                    end
                    2'b01: entry0 <= entry1;
                    2'b11: begin
                        if (count == 2'd1) begin
                            entry0 <= push_entry;
                        end else begin
                            entry0 <= entry1;
                            entry1 <= push_entry;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one bus request outstanding and feeds decode.
// Define FETCH_PREFETCH_EN for a 2-entry run-ahead buffer; otherwise a single entry is held.
module fetch
    import common::*;
    import pipes::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stopd,
    input  logic        stope,
    input  logic        stopm,
    input  logic        branch,
    input  word_t       branch_target,
    output logic        ireq_valid,
    output word_t       ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output fetch_data_t dataF
);
`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] QDEPTH = 2'd2;
`else
    localparam logic [1:0] QDEPTH = 2'd1;
`endif

    fetch_state_t state;
    word_t        pc;
    word_t        drop_addr;
    logic         stall;
    logic         accept;
    logic         bypass;
    logic         push;
    logic         pop;
    logic         full_next;
    logic [1:0]   q_count;
    fetch_entry_t head;
    fetch_entry_t resp_entry;

    assign stall      = stopd | stope | stopm;
    assign accept     = (state == REQ) && iresp_data_ok && !branch;
    assign pop        = !stall && (q_count != 2'd0);
    assign bypass     = accept && !stall && (q_count == 2'd0);
    assign push       = accept && !bypass;
    assign resp_entry = '{pc: pc, instr: iresp_data};

    // In DROP the PC already points at the branch target, so the abandoned address is replayed.
    assign ireq_valid = (state != FULL);
    assign ireq_addr  = (state == DROP) ? drop_addr : pc;

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (branch),
        .push_entry(resp_entry),
        .head      (head),
        .count     (q_count),
        .full_next (full_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            dataF     <= '0;
        end else if (branch) begin
            pc          <= branch_target;
            dataF.valid <= 1'b0;
            // An unanswered request must still be completed on the bus before refetching.
            if (state != FULL && !iresp_data_ok) begin
                state <= DROP;
                if (state == REQ)
                    drop_addr <= pc;
            end else begin
                state <= REQ;
            end
        end else begin
            if (accept)
                pc <= pc + 64'd4;
            if (!stall) begin
                if (pop)
                    dataF <= '{valid: 1'b1, pc: head.pc, instr: head.instr};
                else if (bypass)
                    dataF <= '{valid: 1'b1, pc: pc, instr: iresp_data};
                else
                    dataF.valid <= 1'b0;
            end
            case (state)
                REQ:     if (full_next) state <= FULL;
                FULL:    if (!full_next) state <= REQ;
                DROP:    if (iresp_data_ok) state <= REQ;
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage; expectations follow the FETCH_PREFETCH_EN build.
module tb_fetch;
    import pipes::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stopd = 1'b0;
    logic        stope = 1'b0;
    logic        stopm = 1'b0;
    logic        branch = 1'b0;
    logic [63:0] branch_target = '0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    fetch_data_t dataF;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stopd        (stopd),
        .stope        (stope),
        .stopm        (stopm),
        .branch       (branch),
        .branch_target(branch_target),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .dataF        (dataF)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cycle();
        checks++;
        if (ireq_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_ireq_valid: got %b want 1", ireq_valid); end
        checks++;
        if (ireq_addr !== RST_PC) begin errors++; $display("[TB] FAIL rst_ireq_addr: got %h want %h", ireq_addr, RST_PC); end
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_dataF_valid: got %b want 0", dataF.valid); end
        checks++;
        if (dataF.pc !== 64'd0) begin errors++; $display("[TB] FAIL rst_dataF_pc: got %h want 0", dataF.pc); end
        reset = 1'b1;
        cycle();
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
            errors++; $display("[TB] FAIL post_rst_req: got %b/%h want 1/%h", ireq_valid, ireq_addr, RST_PC);
        end
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_valid: got %b want 0", dataF.valid); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            iresp_data_ok = 1'b1;
            iresp_data    = 32'h0000_0013;
            cycle();
            checks++;
            if (dataF.valid !== 1'b1 || dataF.pc !== RST_PC + 64'(4 * k) || dataF.instr !== 32'h13) begin
                errors++;
                $display("[TB] FAIL stream_%0d: got %b/%h/%h want 1/%h/00000013", k, dataF.valid, dataF.pc, dataF.instr, RST_PC + 64'(4 * k));
            end
        end
        iresp_data_ok = 1'b0;
        cycle();
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_idle: got %b want 0", dataF.valid); end
    endtask

    task automatic test_stall();
        int completed;
        int expected;
`ifdef FETCH_PREFETCH_EN
        expected = 2;
`else
        expected = 1;
`endif
        completed = 0;
        iresp_data_ok = 1'b1;
        iresp_data    = ireq_addr[31:0];
        cycle();
        stopd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iresp_data_ok = ireq_valid;
            iresp_data    = ireq_addr[31:0];
            if (ireq_valid) completed++;
            cycle();
            checks++;
            if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_000C) begin
                errors++; $display("[TB] FAIL stall_freeze_%0d: got %b/%h want 1/800000000000000c", i, dataF.valid, dataF.pc);
            end
        end
        iresp_data_ok = 1'b0;
        checks++;
        if (ireq_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_off: got %b want 0", ireq_valid); end
        checks++;
        if (completed != expected) begin errors++; $display("[TB] FAIL stall_runahead: got %0d want %0d", completed, expected); end
        stopd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iresp_data_ok = ireq_valid;
            iresp_data    = ireq_addr[31:0];
            cycle();
            checks++;
            if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_0010 + 64'(4 * i) || dataF.instr !== 32'h8000_0010 + 32'(4 * i)) begin
                errors++;
                $display("[TB] FAIL stall_resume_%0d: got %b/%h/%h want 1/%h", i, dataF.valid, dataF.pc, dataF.instr, 64'h8000_0010 + 64'(4 * i));
            end
        end
        iresp_data_ok = 1'b0;
        repeat (3) cycle();
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain: got %b want 0", dataF.valid); end
    endtask

    task automatic test_branch_inflight();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        repeat (4) cycle();
        iresp_data_ok = 1'b0;
        checks++;
        if (ireq_addr !== 64'h8000_0010) begin errors++; $display("[TB] FAIL br_pending_addr: got %h want 80000010", ireq_addr); end
        branch        = 1'b1;
        branch_target = 64'h8000_0100;
        cycle();
        branch = 1'b0;
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin
            errors++; $display("[TB] FAIL br_hold_addr0: got %b/%h want 1/80000010", ireq_valid, ireq_addr);
        end
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL br_flush_valid: got %b want 0", dataF.valid); end
        cycle();
        checks++;
        if (ireq_addr !== 64'h8000_0010) begin errors++; $display("[TB] FAIL br_hold_addr1: got %h want 80000010", ireq_addr); end
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        cycle();
        iresp_data_ok = 1'b0;
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100) begin
            errors++; $display("[TB] FAIL br_target_req: got %b/%h want 1/80000100", ireq_valid, ireq_addr);
        end
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL br_dropped: got %b/%h want valid 0", dataF.valid, dataF.instr); end
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0011;
        cycle();
        iresp_data_ok = 1'b0;
        checks++;
        if (dataF.valid !== 1'b1 || dataF.pc !== 64'h8000_0100 || dataF.instr !== 32'h11) begin
            errors++; $display("[TB] FAIL br_first_target: got %b/%h/%h want 1/80000100/00000011", dataF.valid, dataF.pc, dataF.instr);
        end
    endtask

    task automatic test_coincident();
        branch        = 1'b1;
        branch_target = 64'h8000_0200;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0BAD;
        cycle();
        branch        = 1'b0;
        iresp_data_ok = 1'b0;
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200) begin
            errors++; $display("[TB] FAIL coinc_req: got %b/%h want 1/80000200", ireq_valid, ireq_addr);
        end
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_valid: got %b want 0", dataF.valid); end
        cycle();
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_no_late: got %b want 0", dataF.valid); end
    endtask

    task automatic test_branch_stall();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0022;
        cycle();
        iresp_data_ok = 1'b0;
        stope         = 1'b1;
        branch        = 1'b1;
        branch_target = 64'h8000_0300;
        cycle();
        branch = 1'b0;
        checks++;
        if (dataF.valid !== 1'b0) begin errors++; $display("[TB] FAIL brstall_flush: got %b want 0", dataF.valid); end
        stope         = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0BAD;
        cycle();
        iresp_data_ok = 1'b0;
        checks++;
        if (ireq_addr !== 64'h8000_0300 || dataF.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL brstall_resume: got %h/%b want 80000300/0", ireq_addr, dataF.valid);
        end
    endtask

    task automatic test_async_reset();
        int n;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0033;
        cycle();
        stope = 1'b1;
        n = 0;
        while (ireq_valid && n < 6) begin
            iresp_data_ok = 1'b1;
            iresp_data    = ireq_addr[31:0];
            cycle();
            n++;
        end
        iresp_data_ok = 1'b0;
        checks++;
        if (ireq_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_full: got %b want 0", ireq_valid); end
        checks++;
        if (dataF.pc !== 64'h8000_0300) begin errors++; $display("[TB] FAIL arst_frozen: got %h want 80000300", dataF.pc); end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
            errors++; $display("[TB] FAIL arst_req: got %b/%h want 1/%h", ireq_valid, ireq_addr, RST_PC);
        end
        checks++;
        if (dataF !== '0) begin errors++; $display("[TB] FAIL arst_dataF: got %b/%h/%h want 0/0/0", dataF.valid, dataF.pc, dataF.instr); end
        stope = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        checks++;
        if (ireq_addr !== RST_PC || ireq_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL arst_release: got %b/%h want 1/%h", ireq_valid, ireq_addr, RST_PC);
        end
    endtask

    initial begin
        $display("[TB] fetch bench start");
        test_reset();
        test_stream();
        test_stall();
        test_branch_inflight();
        test_coincident();
        test_branch_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
